// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared states, widths and constants for the pipeline memory arbiter
package pipe_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  typedef enum logic [1:0] {ARB, MEM, IF, REL} arb_state_t;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts stalled bus cycles and flags expiry after TIMEOUT of them
//   clk/rst   : clock, asynchronous active-low reset
//   i_clr     : clear the count (state change)
//   i_en      : a cycle spent waiting on the bus without ack
//   o_expire  : this waiting cycle is the TIMEOUT-th one; 0 when TIMEOUT=0
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + CW'(1);
  // Expiry fires in the waiting cycle that would bring the count to TIMEOUT.
  assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: serialises data access then fetch onto one shared memory bus
//   clk/rst                 : clock, asynchronous active-low reset
//   if_addr / if_rdata      : fetch address in, captured instruction out
//   mem_rd/mem_wr/mem_addr/mem_wdata / mem_rdata : data port in, captured load data out
//   pipe_stall              : holds PC and pipeline registers while not releasing
//   bus_req/we/addr/wdata   : shared bus request, held stable until the ack edge
//   bus_rdata/bus_ack       : bus read data and completion
//   bus_err                 : sticky watchdog timeout flag
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);
  arb_state_t        r_state, w_next;
  logic              r_wr;
  logic [ADDR_W-1:0] r_if_addr, r_mem_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_busy, w_expire, w_done;
  assign w_busy = (r_state == MEM) || (r_state == IF);
  assign w_done = w_busy && (bus_ack || w_expire);
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != w_next),
    .i_en     (w_busy && !bus_ack),
    .o_expire (w_expire)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= ARB;
    else r_state <= w_next;
  // Bus outputs and stall decode from the registered state only.
  always_comb begin
    w_next     = r_state;
    pipe_stall = (r_state != REL);
    bus_req    = w_busy;
    bus_we     = (r_state == MEM) && r_wr;
    bus_addr   = (r_state == MEM) ? r_mem_addr : (r_state == IF) ? r_if_addr : '0;
    bus_wdata  = (r_state == MEM) ? r_wdata : '0;
    unique case (r_state)
      ARB:     w_next = (mem_rd || mem_wr) ? MEM : IF;
      MEM:     w_next = w_done ? IF : MEM;
      IF:      w_next = w_done ? REL : IF;
      default: w_next = ARB;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr       <= 1'b0;
      r_if_addr  <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      if_rdata   <= DATA_W'(NOP_INST);
      mem_rdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      if (r_state == ARB) begin
        r_wr       <= mem_wr;
        r_if_addr  <= if_addr;
        r_mem_addr <= mem_addr;
        r_wdata    <= mem_wdata;
        // A simultaneous read+write runs as a write with no load result.
        if (mem_rd && mem_wr) mem_rdata <= '0;
      end
      if (r_state == MEM && w_done && !r_wr) mem_rdata <= w_expire ? '0 : bus_rdata;
      if (r_state == IF && w_done) if_rdata <= w_expire ? DATA_W'(NOP_INST) : bus_rdata;
      if (w_expire) bus_err <= 1'b1;
    end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed self-checking bench for pipe_mem_arbiter
module tb_pipe_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_addr = '0, if_rdata;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic        pipe_stall, bus_req, bus_we, bus_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pipe_stall (pipe_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic arb(input logic rd, input logic wr, input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
    chk("arb_stall", pipe_stall, 1);
    chk("arb_req", bus_req, 0);
    mem_rd = rd; mem_wr = wr; if_addr = ia; mem_addr = ma; mem_wdata = wd;
    tick;
    mem_rd = 1'b1; mem_wr = 1'b1; if_addr = 32'hFFFF_FFF4; mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'hA5A5_A5A5;
  endtask
  task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input int wait_n, input logic [31:0] rd);
    for (int i = 0; i <= wait_n; i++) begin
      chk({tag, "_req"}, bus_req, 1);
      chk({tag, "_we"}, bus_we, we);
      chk({tag, "_addr"}, bus_addr, a);
      if (we) chk({tag, "_wdata"}, bus_wdata, wd);
      chk({tag, "_stall"}, pipe_stall, 1);
      bus_ack = (i == wait_n);
      bus_rdata = (i == wait_n) ? rd : 32'hBAD0_BAD0;
      tick;
    end
    bus_ack = 1'b0;
  endtask
  task automatic tmo(input string tag, input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_req"}, bus_req, 1);
      chk({tag, "_addr"}, bus_addr, a);
      bus_ack = 1'b0;
      bus_rdata = 32'hBAD0_BAD0;
      tick;
    end
  endtask
  task automatic rel(input logic [31:0] ir, input logic [31:0] mr);
    chk("rel_stall", pipe_stall, 0);
    chk("rel_req", bus_req, 0);
    chk("rel_if_rdata", if_rdata, ir);
    chk("rel_mem_rdata", mem_rdata, mr);
    tick;
  endtask
  initial begin
    #2 rst = 1'b0;
    tick; tick;
    chk("rst_stall", pipe_stall, 1);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_if_rdata", if_rdata, 32'h00000013);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_err", bus_err, 0);
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      arb(0, 0, 32'h0, 32'h0, 32'h0);
      xact("fetch", 0, 32'h0, 32'h0, 0, 32'h00500093);
      rel(32'h00500093, 32'h0);
    end
    arb(1, 0, 32'h4, 32'h100, 32'h0);
    xact("load", 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    xact("load_f", 0, 32'h4, 32'h0, 0, 32'h00000013);
    rel(32'h00000013, 32'hDEADBEEF);
    arb(0, 1, 32'h8, 32'h200, 32'h12345678);
    xact("store", 1, 32'h200, 32'h12345678, 3, 32'h0);
    xact("store_f", 0, 32'h8, 32'h0, 0, 32'h00a00113);
    rel(32'h00a00113, 32'hDEADBEEF);
    chk("store_err", bus_err, 0);
    arb(1, 1, 32'hC, 32'h40, 32'hCAFEF00D);
    xact("rdwr", 1, 32'h40, 32'hCAFEF00D, 0, 32'h55555555);
    xact("rdwr_f", 0, 32'hC, 32'h0, 0, 32'h00108093);
    rel(32'h00108093, 32'h0);
    arb(0, 0, 32'h10, 32'h0, 32'h0);
    tmo("tmo_f", 32'h10);
    rel(32'h00000013, 32'h0);
    chk("tmo_err", bus_err, 1);
    arb(1, 0, 32'h14, 32'h300, 32'h0);
    xact("load2", 0, 32'h300, 32'h0, 0, 32'h00000077);
    xact("load2_f", 0, 32'h14, 32'h0, 0, 32'h00000013);
    rel(32'h00000013, 32'h00000077);
    chk("err_sticky", bus_err, 1);
    arb(1, 0, 32'h18, 32'h304, 32'h0);
    tmo("tmo_l", 32'h304);
    xact("tmo_l_f", 0, 32'h18, 32'h0, 0, 32'h00300193);
    rel(32'h00300193, 32'h0);
    chk("err_sticky2", bus_err, 1);
    arb(1, 0, 32'h1C, 32'h500, 32'h0);
    chk("mid_req1", bus_req, 1);
    tick;
    chk("mid_req2", bus_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_stall", pipe_stall, 1);
    chk("mid_rst_addr", bus_addr, 0);
    chk("mid_rst_if_rdata", if_rdata, 32'h00000013);
    chk("mid_rst_mem_rdata", mem_rdata, 0);
    chk("mid_rst_err", bus_err, 0);
    tick;
    rst = 1'b1;
    arb(0, 0, 32'h20, 32'h0, 32'h0);
    xact("post_rst_f", 0, 32'h20, 32'h0, 0, 32'h02000093);
    rel(32'h02000093, 32'h0);
    chk("post_rst_err", bus_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
